// File: rtl/xdma_byp_pkg.sv
// Shared types and constants for the XDMA descriptor-bypass arbiter.
// Control-field bit positions follow the XDMA descriptor ctl layout.
package xdma_byp_pkg;

    localparam int XDMA_CTL_WIDTH = 16;

    localparam int CTL_STOP      = 0;
    localparam int CTL_COMPLETED = 1;
    localparam int CTL_EOP       = 4;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_LEN_WIDTH  = 28;
    localparam int DEF_NUM_REQ    = 4;

    localparam int REQ_ID_WIDTH = $clog2(DEF_NUM_REQ);
    typedef logic [REQ_ID_WIDTH-1:0] req_id_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byp_id_fifo.sv
// Requester-id FIFO tracking the issuer of every in-flight descriptor.
// Push and pop may coincide, including when full or holding one entry.
module byp_id_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_id,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_id  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/xdma_desc_byp_arbiter.sv
// Round-robin arbiter sharing one XDMA descriptor-bypass channel,
// with outstanding-credit limiting and in-order completion routing.
module xdma_desc_byp_arbiter
    import xdma_byp_pkg::*;
#(
    parameter  int NUM_REQ         = DEF_NUM_REQ,
    parameter  int MAX_OUTSTANDING = 8,
    parameter  int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter  int LEN_WIDTH       = DEF_LEN_WIDTH,
    localparam int ID_W            = id_width(NUM_REQ),
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING) + 1,
    localparam int CTL_W           = XDMA_CTL_WIDTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_REQ*CTL_W-1:0]      req_ctl,
    input  logic                          dsc_byp_ready,
    output logic                          dsc_byp_load,
    output logic [ADDR_WIDTH-1:0]         dsc_byp_src_addr,
    output logic [ADDR_WIDTH-1:0]         dsc_byp_dst_addr,
    output logic [LEN_WIDTH-1:0]          dsc_byp_len,
    output logic [CTL_W-1:0]              dsc_byp_ctl,
    input  logic                          desc_done,
    output logic [NUM_REQ-1:0]            cpl_valid,
    output logic [OUT_W-1:0]              outstanding,
    output logic                          err_spurious_done
);

    logic            slot_full;
    logic            accept;
    logic            can_grant;
    logic            grant_found;
    logic            grant;
    logic            pop_ok;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] head_id;
    logic [OUT_W-1:0] count;

    assign accept    = slot_full && dsc_byp_ready;
    // Reset also masks the combinational grant so req_ready drops at once.
    assign can_grant = !RST && (!slot_full || accept) &&
                       (count < OUT_W'(MAX_OUTSTANDING));
    assign grant     = can_grant && grant_found;
    assign pop_ok    = desc_done && (count != '0);

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found &&
                req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready    = grant ? (NUM_REQ'(1) << grant_id) : '0;
    assign dsc_byp_load = slot_full;
    assign outstanding  = count;

    byp_id_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(ID_W)
    ) u_id_fifo (
        .clk    (CLK),
        .rst    (RST),
        .push   (grant),
        .push_id(grant_id),
        .pop    (desc_done),
        .pop_id (head_id),
        .count  (count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_full        <= 1'b0;
            rr_ptr           <= ID_W'(NUM_REQ - 1);
            dsc_byp_src_addr <= '0;
            dsc_byp_dst_addr <= '0;
            dsc_byp_len      <= '0;
            dsc_byp_ctl      <= '0;
        end else if (grant) begin
            slot_full        <= 1'b1;
            rr_ptr           <= grant_id;
            dsc_byp_src_addr <=
                req_src_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
            dsc_byp_dst_addr <=
                req_dst_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
            dsc_byp_len      <=
                req_len[int'(grant_id)*LEN_WIDTH +: LEN_WIDTH];
            dsc_byp_ctl      <=
                req_ctl[int'(grant_id)*CTL_W +: CTL_W];
        end else if (accept) begin
            slot_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpl_valid         <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            cpl_valid <= pop_ok ? (NUM_REQ'(1) << head_id) : '0;
            if (desc_done && (count == '0))
                err_spurious_done <= 1'b1;
        end
    end

endmodule

// File: doc/xdma_desc_byp_arbiter.md
Name: xdma_desc_byp_arbiter

Overview:
- Shares one XDMA descriptor-bypass channel (H2C or C2H; one instance per direction) between NUM_REQ requesters.
- Round-robin arbitration; holds the granted descriptor on the bypass port until XDMA accepts it.
- Limits in-flight descriptors to MAX_OUTSTANDING and routes each desc_done pulse back to the requester that issued it.
- Sits between user-logic DMA engines and the xdma_0 dsc_byp_* / sts[3] signals, in the user clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_OUTSTANDING, 8: descriptors accepted by XDMA but not yet done (power of 2, 2..32).
- ADDR_WIDTH, 64: src/dst address width.
- LEN_WIDTH, 28: descriptor length width.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester descriptor valid.
- req_ready  out  NUM_REQ  one-hot grant pulse; descriptor consumed.
- req_src_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at slice i.
- req_dst_addr  in  NUM_REQ*ADDR_WIDTH  flattened.
- req_len  in  NUM_REQ*LEN_WIDTH  flattened, byte count.
- req_ctl  in  NUM_REQ*16  flattened XDMA control field.
- dsc_byp_ready  in  1  XDMA can take a descriptor.
- dsc_byp_load  out  1  descriptor presented.
- dsc_byp_src_addr  out  ADDR_WIDTH
- dsc_byp_dst_addr  out  ADDR_WIDTH
- dsc_byp_len  out  LEN_WIDTH
- dsc_byp_ctl  out  16
- desc_done  in  1  one-cycle completion pulse (sts[3]).
- cpl_valid  out  NUM_REQ  one-hot completion pulse to the owning requester.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count.
- err_spurious_done  out  1  sticky: desc_done seen with nothing in flight.

Behaviour:
- Reset state: all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; ID FIFO empty; outstanding = 0. Reset asserted mid-operation drops the presented descriptor and all in-flight tracking.
- Slot state: the output slot is EMPTY or FULL. When FULL, dsc_byp_load = 1 and dsc_byp_* are stable.
- XDMA accept: a cycle where FULL and dsc_byp_ready = 1. Next cycle the slot is EMPTY unless a new grant is made in the same cycle, which allows back-to-back descriptors with load held high.
- Grant condition: the slot is EMPTY or being accepted this cycle, at least one req_valid is set, and outstanding < MAX_OUTSTANDING.
- Grant selection: first requester with req_valid set, searching upward from rr_ptr+1 with wrap-around.
- Grant actions:
  - req_ready[g] = 1 combinationally in that cycle.
  - Requester g's fields are registered into dsc_byp_*; slot is FULL next cycle.
  - g is pushed into the ID FIFO; rr_ptr <= g.
- Latency: req_valid to dsc_byp_load is 1 cycle when the slot is free.
- Requester rule: req fields must stay stable while req_valid is high and req_ready is low.
- outstanding: +1 on grant, -1 on desc_done; unchanged when both happen in the same cycle. Never exceeds MAX_OUTSTANDING.
- desc_done, outstanding > 0:
  - Pop the FIFO head h.
  - cpl_valid[h] = 1 the next cycle (registered, single-cycle pulse).
  - Completions return in issue order.
- desc_done, outstanding == 0: ignored; err_spurious_done is set and holds until RST.
- Simultaneous grant and desc_done with the FIFO holding one entry: the pop returns the old head; the push is retained.
- A requester holding req_valid high gets at most one grant per NUM_REQ grants while others are also requesting.

Decomposition:
- Shared package xdma_byp_pkg:
  - XDMA_CTL_WIDTH = 16.
  - ctl bit constants: CTL_STOP = 0, CTL_COMPLETED = 1, CTL_EOP = 4.
  - default ADDR_WIDTH / LEN_WIDTH.
  - requester-id typedef sized $clog2(NUM_REQ).
- Sub-module byp_id_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width $clog2(NUM_REQ).
  - Simultaneous push/pop is legal, including when the FIFO is full.
  - Exposes count, which drives outstanding.

Test Plan:
- Single request: req 2 valid, src 0x1000, dst 0x0, len 64, dsc_byp_ready = 1 → req_ready[2] at cycle 0; load = 1 with src 0x1000 at cycle 1 for one cycle; desc_done at cycle 5 → cpl_valid = 4'b0100 at cycle 6; outstanding returns to 0.
- Round-robin: all 4 requesters valid continuously, ready = 1, done returned 3 cycles after each accept → grant order 0,1,2,3,0,1…; back-to-back loads with no idle cycle.
- Backpressure: ready = 0 for 10 cycles while load is high → dsc_byp_* fields unchanged for all 10 cycles; accept on the first cycle ready = 1; no second grant until then.
- Credit limit: MAX_OUTSTANDING = 8, desc_done never sent → exactly 8 grants, then req_ready stays 0 and outstanding = 8. One desc_done → exactly one further grant, outstanding stays 8.
- Simultaneous grant and done at outstanding = 3 → outstanding stays 3; cpl_valid goes to the oldest issuer.
- Spurious done: desc_done with outstanding = 0 → no cpl_valid, err_spurious_done = 1. Reset mid-burst (RST high with load = 1) → all outputs 0 immediately and err_spurious_done cleared.
